spike_event_encoder: RTL
========================

Name: spike_event_encoder

Overview:
- Sits directly downstream of tdm_controller and consumes its time-multiplexed membrane stream: one (neuron id, v) sample per valid cycle.
- Detects per-neuron upward threshold crossings.
- Tags each crossing with the simulation-step timestamp.
- Buffers the resulting address-event (AER) records in a FIFO drained by a valid/ready consumer (spike router or host logger).

Parameters:
- NEURON_COUNT, 500, neurons time-multiplexed per simulation step.
- DATA_WIDTH, 16, signed Q4.12 membrane width; matches tdm_controller data_width.
- TS_WIDTH, 16, timestamp/step counter width, wraps modulo 2^TS_WIDTH.
- FIFO_DEPTH, 16, event FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample valid, one sample per cycle max, no backpressure.
- in_id  in  $clog2(NEURON_COUNT)  neuron index of sample (tdm_controller write pointer).
- in_v  in  DATA_WIDTH  signed membrane potential of sample.
- threshold  in  DATA_WIDTH  signed spike threshold, quasi-static.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts head this cycle.
- ev_id  out  $clog2(NEURON_COUNT)  neuron id of head event.
- ev_ts  out  TS_WIDTH  step timestamp of head event.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- drop_count  out  16  events lost to a full FIFO, saturating.
- step_count  out  TS_WIDTH  completed simulation steps.

Behaviour:
- Reset (rst=0, async):
  - above-flag bitmap (NEURON_COUNT bits) all 0.
  - FIFO empty.
  - ev_valid, ev_id, ev_ts, fifo_count, drop_count and step_count all 0.
  - Deassertion is synchronised internally; first sample accepted on the second rising edge after rst rises.
- Sample acceptance: on a rising edge with in_valid=1 and in_id < NEURON_COUNT:
  - above = ($signed(in_v) >= $signed(threshold)).
  - spike = above && !flag[in_id].
  - flag[in_id] <= above.
- Out-of-range in_id (>= NEURON_COUNT): sample fully ignored; no flag write, no event, no step increment.
- Step counter:
  - Increments, with wrap, on an accepted sample with in_id == NEURON_COUNT-1.
  - That sample's event carries the pre-increment value.
- Event push: on spike, {in_id, step_count} is written to the FIFO on the same edge. Latency is 1 cycle: ev_valid is high the cycle after the sample edge if the FIFO was empty.
- FIFO:
  - First-word fall-through; ev_id/ev_ts are valid whenever ev_valid=1 and are held stable until popped.
  - Pop when ev_valid && ev_ready.
  - ev_id/ev_ts return to 0 when empty.
- Boundary conditions:
  - Push and pop on the same edge: both occur at any occupancy, including full; count unchanged.
  - Push while full with no pop: event dropped, drop_count += 1 (saturates at 16'hFFFF). The flag is still updated, so the crossing is not re-reported.
  - Pop while empty: no effect.
  - Order preserved; no duplicate or reordered events.
  - Threshold change: takes effect on the next sample; flags are not cleared.
  - Reset mid-operation: all state is lost immediately, including buffered events.

Test Plan:
1. Reset: hold rst=0 with in_valid toggling -> all outputs 0. Release, wait 2 edges -> still 0, ev_valid=0.
2. Single crossing, threshold=4096, ev_ready=1:
   - id 3 v=5000 in step 0 -> one event {3, ts 0}, ev_valid 1 cycle later.
   - id 3 v=5000 in step 1 -> no event.
   - id 3 v=100 in step 2 -> no event.
   - id 3 v=4096 in step 3 -> event {3, ts 3}.
3. Timestamp:
   - Three full sweeps ids 0..499 -> step_count=3.
   - Crossing on id 499 in step 0 -> ts 0.
   - Force TS_WIDTH=4 -> step 16 event carries ts 0.
4. Overflow: ev_ready=0, 20 distinct-neuron crossings -> fifo_count=16, drop_count=4. Then ev_ready=1 -> 16 events drained in input order; ids of the last 4 absent.
5. Full with simultaneous pop: FIFO full, ev_ready=1, new crossing -> fifo_count stays 16, drop_count unchanged, new event appears last.
6. Edge cases:
   - Sample id 510, v=8000 -> no event, no flag change, no step increment.
   - rst=0 mid-drain with 5 queued -> fifo_count=0 immediately.
   - After reset, id 3 v=5000 -> event emitted again (flags cleared).

Source files
------------

// File: rtl/spike_event_encoder.sv
// spike_event_encoder
//   Watches a time-multiplexed membrane stream (one neuron sample per valid
//   cycle), detects upward threshold crossings per neuron, stamps each
//   crossing with the current simulation step and queues the resulting
//   address-event record in a first-word fall-through FIFO.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset (release is synchronised)
//   in_valid    sample valid, at most one per cycle, no backpressure
//   in_id       neuron index of the sample
//   in_v        signed membrane potential of the sample
//   threshold   signed spike threshold, quasi-static
//   ev_valid    FIFO head holds an event
//   ev_ready    consumer accepts the head this cycle
//   ev_id       neuron id of the head event (0 when empty)
//   ev_ts       step timestamp of the head event (0 when empty)
//   fifo_count  occupied FIFO entries
//   drop_count  events lost to a full FIFO, saturating
//   step_count  completed simulation steps, wraps
module spike_event_encoder #(
  parameter int NEURON_COUNT = 500,
  parameter int DATA_WIDTH   = 16,
  parameter int TS_WIDTH     = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [$clog2(NEURON_COUNT)-1:0] in_id,
  input  logic [DATA_WIDTH-1:0]           in_v,
  input  logic [DATA_WIDTH-1:0]           threshold,
  output logic                            ev_valid,
  input  logic                            ev_ready,
  output logic [$clog2(NEURON_COUNT)-1:0] ev_id,
  output logic [TS_WIDTH-1:0]             ev_ts,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [15:0]                     drop_count,
  output logic [TS_WIDTH-1:0]             step_count
);

  localparam int ID_W  = $clog2(NEURON_COUNT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int REC_W = ID_W + TS_WIDTH;

  // Compare against NEURON_COUNT one bit wider than the id so the range
  // check also works when NEURON_COUNT is a power of two.
  localparam logic [ID_W:0]     N_EXT   = (ID_W + 1)'(NEURON_COUNT);
  localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NEURON_COUNT - 1);
  localparam logic [CNT_W-1:0]  FULL_N  = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // Reset release: a single flop that goes high one edge after rst rises,
  // so the first sample is taken on the second rising edge.
  // ---------------------------------------------------------------------
  logic run_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Crossing detection
  // ---------------------------------------------------------------------
  logic [NEURON_COUNT-1:0] flags;
  logic                    in_range;
  logic                    accept;
  logic                    above;
  logic                    flag_cur;
  logic                    spike;
  logic                    last_sample;

  assign in_range    = ({1'b0, in_id} < N_EXT);
  assign accept      = run_q && in_valid && in_range;
  assign above       = ($signed(in_v) >= $signed(threshold));
  assign flag_cur    = in_range ? flags[in_id] : 1'b0;
  assign spike       = accept && above && !flag_cur;
  assign last_sample = accept && (in_id == LAST_ID);

  // One flop per neuron: the whole bitmap must clear on reset, so it
  // cannot live in block RAM.
  generate
    for (genvar gi = 0; gi < NEURON_COUNT; gi++) begin : g_flag
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          flags[gi] <= 1'b0;
        end else if (accept && (in_id == ID_W'(gi))) begin
          flags[gi] <= above;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Step counter: the last neuron's sample closes a step; its event keeps
  // the pre-increment value because the FIFO write uses the old count.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_count <= '0;
    end else if (last_sample) begin
      step_count <= step_count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [REC_W-1:0] head;

  assign ev_valid = (count != '0);
  assign full     = (count == FULL_N);
  assign pop      = ev_valid && ev_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push     = spike && (!full || pop);
  assign drop     = spike && full && !pop;

  // Storage has no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_id, step_count};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign head       = mem[rd_ptr];
  assign ev_id      = ev_valid ? head[REC_W-1:TS_WIDTH] : '0;
  assign ev_ts      = ev_valid ? head[TS_WIDTH-1:0] : '0;
  assign fifo_count = count;

endmodule
